// File: rtl/imem_loader_if.sv
// Byte-stream receive link and instruction-memory write port of the boot loader.
interface imem_loader_if #(parameter int ADDR_W = 10);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (input rx_valid, rx_data,
                  output rx_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (output rx_valid, rx_data,
                  input rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a counted little-endian byte stream into imem words, holds core in reset until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t            state_q, state_d;
  logic [15:0]       cnt_q;
  logic [15:0]       widx_q;
  logic [1:0]        lane_q;
  logic [23:0]       wbuf_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready;
  logic              acc;
  logic [15:0]       n_hdr;
  logic              last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  assign acc       = bus.rx_valid && ready;
  assign n_hdr     = {bus.rx_data, cnt_q[7:0]};
  assign last_byte = (lane_q == 2'd3) && (widx_q == cnt_q - 16'd1);

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      S_HDR0: begin
        ready = 1'b1;
        if (acc) state_d = S_HDR1;
      end
      S_HDR1: begin
        ready = 1'b1;
        if (acc) begin
          if ({1'b0, n_hdr} > 17'(MAX_WORDS)) state_d = S_ERR;
          else if (n_hdr == 16'd0)            state_d = S_FIN;
          else                                state_d = S_DATA;
        end
      end
      S_DATA: begin
        ready = 1'b1;
        if (acc && last_byte) state_d = S_FIN;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        ready = 1'b1;
        // whole stream, checksum byte included, must sum to zero mod 256
        if (acc) state_d = (sum_q + bus.rx_data == 8'h00) ? S_DONE : S_ERR;
      end
`endif
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR0;
      cnt_q   <= '0;
      widx_q  <= '0;
      lane_q  <= '0;
      wbuf_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q <= sum_q + bus.rx_data;
`endif
        case (state_q)
          S_HDR0: cnt_q[7:0]  <= bus.rx_data;
          S_HDR1: cnt_q[15:8] <= bus.rx_data;
          S_DATA: begin
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= widx_q[ADDR_W-1:0];
              wdata_q <= {bus.rx_data, wbuf_q};
              widx_q  <= widx_q + 16'd1;
            end else begin
              // bytes arrive LSB first; shift in from the top
              wbuf_q <= {bus.rx_data, wbuf_q[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign load_done      = (state_q == S_DONE);
  assign load_err       = (state_q == S_ERR);
  assign core_rst       = (state_q != S_DONE);

endmodule
